// File: rtl/td4_pkg.sv
// td4_pkg: shared TD4 definitions.
// - 4-bit opcode encodings placed in the upper nibble of each instruction word.
// - Program-memory FSM state encoding.
// - td4_insn() packs an opcode and a 4-bit immediate into an 8-bit instruction.
package td4_pkg;

  localparam logic [3:0] ADD_A_IM = 4'h0;
  localparam logic [3:0] MOV_A_B  = 4'h1;
  localparam logic [3:0] IN_A     = 4'h2;
  localparam logic [3:0] MOV_A_IM = 4'h3;
  localparam logic [3:0] MOV_B_A  = 4'h4;
  localparam logic [3:0] ADD_B_IM = 4'h5;
  localparam logic [3:0] IN_B     = 4'h6;
  localparam logic [3:0] MOV_B_IM = 4'h7;
  localparam logic [3:0] OUT_B    = 4'h9;
  localparam logic [3:0] OUT_IM   = 4'hB;
  localparam logic [3:0] JNC      = 4'hE;
  localparam logic [3:0] JMP      = 4'hF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } pm_state_e;

  function automatic logic [7:0] td4_insn(input logic [3:0] op, input logic [3:0] imm);
    return {op, imm};
  endfunction

endpackage

// File: rtl/prog_mem_boot_image.sv
// prog_mem_boot_image: combinational boot ROM for prog_mem.
// Ports:
//   index  in  ADDR_W  word address
//   word   out DATA_W  boot image word (8-bit instruction zero-extended)
// Addresses 0x0..0xB hold the demo program; everything else reads as zero.
module prog_mem_boot_image
  import td4_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] word
);

  logic [7:0] insn;

  always_comb begin
    insn = 8'h00;
    // Only the first 16 addresses can hold image words; any upper bit set -> 0.
    if ((index >> 4) == '0) begin
      case (index[3:0])
        4'h0:    insn = td4_insn(MOV_A_IM, 4'h1);
        4'h1:    insn = td4_insn(MOV_B_IM, 4'h2);
        4'h2:    insn = td4_insn(MOV_A_B,  4'h0);
        4'h3:    insn = td4_insn(MOV_B_A,  4'h0);
        4'h4:    insn = td4_insn(ADD_A_IM, 4'h3);
        4'h5:    insn = td4_insn(ADD_B_IM, 4'h4);
        4'h6:    insn = td4_insn(IN_A,     4'h0);
        4'h7:    insn = td4_insn(IN_B,     4'h0);
        4'h8:    insn = td4_insn(OUT_IM,   4'h5);
        4'h9:    insn = td4_insn(OUT_B,    4'h0);
        4'hA:    insn = td4_insn(JMP,      4'h6);
        4'hB:    insn = td4_insn(JNC,      4'h7);
        default: insn = 8'h00;
      endcase
    end
    word       = '0;
    word[7:0]  = insn;
  end

endmodule

// File: rtl/prog_mem.sv
// prog_mem: TD4 program memory, synchronous-read RAM with boot and reload.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_en/fetch_addr      fetch request from the PC (served in RUN only)
//   fetch_data/fetch_valid   registered instruction word, one cycle latency
//   ready                    high in RUN
//   load_start               begin a full reprogram (honoured in RUN only)
//   load_valid/load_data     load stream, accepted while load_ready
//   load_ready               high in LOAD
//   load_done                one-cycle pulse after the last load word is written
// After reset the RAM is filled from the boot image, one word per cycle.
module prog_mem
  import td4_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              ready,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done
);

  localparam int DEPTH = 1 << ADDR_W;

  pm_state_e         state;
  logic [ADDR_W:0]   ptr;      // extra bit: reaches DEPTH after the last write
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] boot_word;
  logic [ADDR_W-1:0] waddr;
  logic              last;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  prog_mem_boot_image #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_boot_image (
    .index (waddr),
    .word  (boot_word)
  );

  assign waddr = ptr[ADDR_W-1:0];
  assign last  = &waddr;

  always_comb begin
    wr_en   = 1'b0;
    wr_data = load_data;
    if (!rst) begin
      if (state == ST_BOOT) begin
        wr_en   = 1'b1;
        wr_data = boot_word;
      end else if (state == ST_LOAD) begin
        wr_en = load_valid && load_ready;
      end
    end
  end

  // RAM array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wr_data;
  end

  // Fetches are only served in RUN, so reads never collide with writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      ptr         <= '0;
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
      ready       <= 1'b0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      load_done   <= 1'b0;
      case (state)
        ST_BOOT: begin
          ptr <= ptr + 1'b1;
          if (last) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (fetch_en) begin
            fetch_data  <= mem[fetch_addr];
            fetch_valid <= 1'b1;
          end
          if (load_start) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            ready      <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (wr_en) begin
            ptr <= ptr + 1'b1;
            if (last) begin
              state      <= ST_RUN;
              ready      <= 1'b1;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
module tb_prog_mem;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: default geometry
  logic       rst = 1'b1;
  logic       fetch_en = 1'b0;
  logic [3:0] fetch_addr = '0;
  logic [7:0] fetch_data;
  logic       fetch_valid, ready;
  logic       load_start = 1'b0, load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready, load_done;

  prog_mem u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid), .ready(ready),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done)
  );

  // DUT 2: wide geometry
  logic        rst2 = 1'b1;
  logic        fetch_en2 = 1'b0;
  logic [4:0]  fetch_addr2 = '0;
  logic [11:0] fetch_data2;
  logic        fetch_valid2, ready2, load_ready2, load_done2;
  logic        load_start2 = 1'b0, load_valid2 = 1'b0;
  logic [11:0] load_data2 = '0;

  prog_mem #(.ADDR_W(5), .DATA_W(12)) u_dut2 (
    .clk(clk), .rst(rst2), .fetch_en(fetch_en2), .fetch_addr(fetch_addr2),
    .fetch_data(fetch_data2), .fetch_valid(fetch_valid2), .ready(ready2),
    .load_start(load_start2), .load_valid(load_valid2), .load_data(load_data2),
    .load_ready(load_ready2), .load_done(load_done2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [7:0] boot_lit [16] = '{8'h31, 8'h72, 8'h10, 8'h40, 8'h03, 8'h54, 8'h20, 8'h60,
                                8'hB5, 8'h90, 8'hF6, 8'hE7, 8'h00, 8'h00, 8'h00, 8'h00};

  // ---------------- behavioural model of DUT 1 ----------------
  function automatic logic [7:0] image_word(input int a);
    case (a)
      0: return 8'h31;  1: return 8'h72;  2: return 8'h10;  3: return 8'h40;
      4: return 8'h03;  5: return 8'h54;  6: return 8'h20;  7: return 8'h60;
      8: return 8'hB5;  9: return 8'h90; 10: return 8'hF6; 11: return 8'hE7;
      default: return 8'h00;
    endcase
  endfunction

  int         m_mode = 0;   // 0 booting, 1 running, 2 loading
  int         m_cnt  = 0;   // words written in the current boot/load
  logic [7:0] m_mem [16];
  logic [7:0] e_data = '0;
  logic       e_valid = 0, e_ready = 0, e_lready = 0, e_ldone = 0;
  bit         live = 0;

  always @(posedge clk) begin
    e_valid = 0;
    e_ldone = 0;
    if (rst) begin
      live   = 1;
      m_mode = 0;
      m_cnt  = 0;
      e_data = '0;
    end else if (m_mode == 0) begin
      m_mem[m_cnt] = image_word(m_cnt);
      m_cnt++;
      if (m_cnt == 16) m_mode = 1;
    end else if (m_mode == 1) begin
      if (fetch_en) begin
        e_data  = m_mem[fetch_addr];
        e_valid = 1;
      end
      if (load_start) begin
        m_mode = 2;
        m_cnt  = 0;
      end
    end else begin
      if (load_valid) begin
        m_mem[m_cnt] = load_data;
        m_cnt++;
        if (m_cnt == 16) begin
          m_mode  = 1;
          e_ldone = 1;
        end
      end
    end
    e_ready  = (m_mode == 1);
    e_lready = (m_mode == 2);
    #1;
    if (live) begin
      chk("fetch_valid", fetch_valid, e_valid);
      chk("fetch_data", fetch_data, e_data);
      chk("ready", ready, e_ready);
      chk("load_ready", load_ready, e_lready);
      chk("load_done", load_done, e_ldone);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst        = 1'b0;
    load_start = 1'b1;   // must be ignored during BOOT
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #2;
      chk("boot_ready_timing", ready, (i == 16));
    end

    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fetch_en   = 1'b1;
      fetch_addr = 4'(i);
      @(posedge clk); #2;
      chk("boot_fetch", fetch_data, boot_lit[i]);
      chk("boot_fetch_valid", fetch_valid, 1);
      @(negedge clk);
    end
    fetch_en = 1'b0;

    // full reload with load_valid toggling, fetch attempts during LOAD
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    fetch_en   = 1'b1;
    fetch_addr = 4'd3;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(8'h10 + i);
      @(posedge clk); #2;
      if (i == 15) chk("load_done_pulse", load_done, 1);
      else         chk("fetch_in_load", fetch_valid, 0);
      @(negedge clk);
      load_valid = 1'b0;
      @(negedge clk);
    end
    fetch_addr = 4'd5;
    @(posedge clk); #2;
    chk("fetch5_reloaded", fetch_data, 8'h15);
    @(negedge clk);
    fetch_en = 1'b0;

    // reset in the middle of a load restores the boot image
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(8'h10 + i);
      @(negedge clk);
    end
    load_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    chk("ready_after_reboot", ready, 1);
    fetch_en   = 1'b1;
    fetch_addr = 4'd2;
    @(posedge clk); #2;
    chk("fetch2_rebooted", fetch_data, 8'h10);

    // load_start and fetch in the same cycle
    @(negedge clk);
    fetch_addr = 4'd8;
    load_start = 1'b1;
    @(posedge clk); #2;
    chk("same_cycle_data", fetch_data, 8'hB5);
    chk("same_cycle_valid", fetch_valid, 1);
    chk("same_cycle_load_ready", load_ready, 1);
    @(negedge clk);
    load_start = 1'b0;
    @(posedge clk); #2;
    chk("fetch_ignored_in_load", fetch_valid, 0);
    @(negedge clk);
    fetch_en = 1'b0;

    // wide geometry: 32-cycle boot, zero-extended image
    rst2 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #2;
      chk("wide_boot_ready_timing", ready2, (i == 32));
    end
    @(negedge clk);
    fetch_en2   = 1'b1;
    fetch_addr2 = 5'd8;
    @(posedge clk); #2;
    chk("wide_fetch8", fetch_data2, 12'h0B5);
    @(negedge clk);
    fetch_addr2 = 5'd20;
    @(posedge clk); #2;
    chk("wide_fetch20", fetch_data2, 12'h000);
    chk("wide_fetch20_valid", fetch_valid2, 1);
    @(negedge clk);
    fetch_en2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
